// File: rtl/fetch_prefetch_q.sv
// AHB-Lite instruction fetch stage: sequential next-PC, pipelined address/data phases,
// a DEPTH-entry prefetch queue and a registered IF/ID output with redirect, stall and error tagging.
module fetch_prefetch_q #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] HRDATA_I,
    input  logic        HREADY_I,
    input  logic        HRESP_I,
    output logic [31:0] HADDR_I,
    output logic [1:0]  HTRANS_I,
    output logic        HWRITE_I,
    output logic [2:0]  HSIZE_I,
    output logic [2:0]  HBURST_I,
    output logic [3:0]  HPROT_I,
    output logic        HMASTLOCK_I,
    output logic [31:0] HWDATA_I,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic        IF_ID_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_NONSEQ = 2'b10
    } htrans_e;

    htrans_e     r_htrans;
    logic [31:0] r_haddr;
    logic [31:0] r_pc;
    logic        r_aph_drop;
    logic        r_dph_v;
    logic        r_dph_drop;
    logic [31:0] r_dph_addr;
    logic        r_halt;
    logic        r_pend;
    logic [31:0] r_pend_pc;

    logic [31:0] r_q_pc   [DEPTH];
    logic [31:0] r_q_inst [DEPTH];
    logic        r_q_err  [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    logic        w_aph_v;
    logic        w_kill;
    logic [31:0] w_target;
    logic        w_push;
    logic        w_pop;
    logic        w_clear;
    logic        w_err_hit;
    logic        w_cancel;
    logic        w_issue;
    logic [1:0]  w_inflight;
    logic [SW-1:0] w_sum;

    assign HADDR_I     = r_haddr;
    assign HTRANS_I    = r_htrans;
    assign HWRITE_I    = 1'b0;
    assign HSIZE_I     = 3'b010;
    assign HBURST_I    = 3'b000;
    assign HPROT_I     = 4'b0011;
    assign HMASTLOCK_I = 1'b0;
    assign HWDATA_I    = '0;

    // A pending (wait-state) redirect behaves like a live one until it is applied.
    always_comb begin
        w_aph_v    = (r_htrans == HT_NONSEQ);
        w_kill     = redirect | r_pend;
        w_target   = redirect ? (redirect_pc & 32'hFFFF_FFFC) : r_pend_pc;
        w_push     = HREADY_I & r_dph_v & ~r_dph_drop & ~w_kill;
        w_clear    = redirect | (HREADY_I & r_pend);
        w_pop      = ~redirect & ~stall & (r_cnt != '0);
        w_err_hit  = r_dph_v & ~r_dph_drop & ~w_kill & HRESP_I;
        w_cancel   = ~HREADY_I & HRESP_I & r_dph_v;
        w_inflight = {1'b0, w_aph_v} + {1'b0, r_dph_v};
        w_sum      = SW'(r_cnt) + SW'(w_inflight);
        w_issue    = ~r_halt & ~w_err_hit & (w_sum < SW'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            r_pc       <= RESET_PC;
            r_haddr    <= RESET_PC;
            r_htrans   <= HT_IDLE;
            r_aph_drop <= 1'b0;
            r_dph_v    <= 1'b0;
            r_dph_drop <= 1'b0;
            r_dph_addr <= '0;
            r_halt     <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_pc  <= '0;
        end else if (HREADY_I) begin
            r_dph_v    <= w_aph_v;
            r_dph_addr <= r_haddr;
            r_dph_drop <= r_aph_drop | w_kill;
            if (w_kill) begin
                r_pc       <= w_target;
                r_htrans   <= HT_IDLE;
                r_aph_drop <= 1'b0;
                r_halt     <= 1'b0;
                r_pend     <= 1'b0;
            end else if (w_issue) begin
                r_haddr    <= r_pc;
                r_htrans   <= HT_NONSEQ;
                r_pc       <= r_pc + 32'd4;
                r_aph_drop <= 1'b0;
            end else begin
                r_htrans   <= HT_IDLE;
                r_aph_drop <= 1'b0;
                if (w_err_hit) r_halt <= 1'b1;
            end
        end else begin
            if (redirect) begin
                r_pend     <= 1'b1;
                r_pend_pc  <= w_target;
                r_aph_drop <= 1'b1;
                r_dph_drop <= 1'b1;
            end
            // First cycle of a two-cycle error: cancel the queued address phase and
            // rewind pc so that word is refetched if the error belonged to a dropped transfer.
            if (w_cancel) begin
                r_htrans <= HT_IDLE;
                if (w_aph_v && !r_aph_drop && !redirect) r_pc <= r_haddr;
                if (!r_dph_drop && !w_kill) r_halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_wr]   <= r_dph_addr;
            r_q_inst[r_wr] <= HRESP_I ? BUBBLE : HRDATA_I;
            r_q_err[r_wr]  <= HRESP_I;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES || w_clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            IF_ID_pc    <= '0;
            IF_ID_inst  <= BUBBLE;
            IF_ID_valid <= 1'b0;
            IF_ID_err   <= 1'b0;
        end else if (redirect) begin
            IF_ID_inst  <= BUBBLE;
            IF_ID_valid <= 1'b0;
            IF_ID_err   <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                IF_ID_pc    <= r_q_pc[r_rd];
                IF_ID_inst  <= r_q_inst[r_rd];
                IF_ID_valid <= ~r_q_err[r_rd];
                IF_ID_err   <= r_q_err[r_rd];
            end else begin
                IF_ID_inst  <= BUBBLE;
                IF_ID_valid <= 1'b0;
                IF_ID_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Bench for fetch_prefetch_q: behavioural AHB slave plus directed scenarios and a
// randomized run scored against a program-order fetch-stream model.
module tb_fetch_prefetch_q;

    localparam logic [31:0] BUB  = 32'hDEAD_0013;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] HRDATA_I;
    logic        HREADY_I;
    logic        HRESP_I;
    logic [31:0] HADDR_I;
    logic [1:0]  HTRANS_I;
    logic        HWRITE_I;
    logic [2:0]  HSIZE_I;
    logic [2:0]  HBURST_I;
    logic [3:0]  HPROT_I;
    logic        HMASTLOCK_I;
    logic [31:0] HWDATA_I;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
    logic        IF_ID_err;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // slave state and knobs
    logic        s_dv = 1'b0;
    logic [31:0] s_daddr = '0;
    int unsigned s_wait = 0;
    logic        s_errph = 1'b0;
    logic [31:0] k_wait_addr = NONE;
    int unsigned k_wait_n = 0;
    logic        k_rand_wait = 1'b0;
    logic [31:0] k_err_addr = NONE;

    fetch_prefetch_q #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .BUBBLE   (BUB)
    ) dut (
        .CLK         (CLK),
        .RES         (RES),
        .HRDATA_I    (HRDATA_I),
        .HREADY_I    (HREADY_I),
        .HRESP_I     (HRESP_I),
        .HADDR_I     (HADDR_I),
        .HTRANS_I    (HTRANS_I),
        .HWRITE_I    (HWRITE_I),
        .HSIZE_I     (HSIZE_I),
        .HBURST_I    (HBURST_I),
        .HPROT_I     (HPROT_I),
        .HMASTLOCK_I (HMASTLOCK_I),
        .HWDATA_I    (HWDATA_I),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_valid (IF_ID_valid),
        .IF_ID_err   (IF_ID_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
    endfunction

    // One clock: drive slave response for the coming edge, take the edge, update slave, settle to negedge.
    task automatic tick();
        logic [31:0] pa;
        logic [1:0]  pt;
        pa = HADDR_I;
        pt = HTRANS_I;
        HRDATA_I = 32'h0BAD_F00D;
        if (s_dv && s_wait > 0) begin
            HREADY_I = 1'b0; HRESP_I = 1'b0; s_wait--;
        end else if (s_dv && s_daddr == k_err_addr) begin
            HRESP_I = 1'b1;
            if (!s_errph) begin HREADY_I = 1'b0; s_errph = 1'b1; end
            else HREADY_I = 1'b1;
        end else begin
            HREADY_I = 1'b1; HRESP_I = 1'b0;
            if (s_dv) HRDATA_I = mem(s_daddr);
        end
        @(posedge CLK);
        if (!RES) s_dv = 1'b0;
        else if (HREADY_I) begin
            s_dv = (pt == 2'b10);
            s_daddr = pa;
            s_errph = 1'b0;
            if (pa == k_wait_addr) s_wait = k_wait_n;
            else if (k_rand_wait && $urandom_range(0, 3) == 0) s_wait = $urandom_range(1, 2);
            else s_wait = 0;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RES = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        tick(); tick();
        n_total++; if (HADDR_I !== 32'h0) $display("FAIL reset_haddr got=%h exp=%h", HADDR_I, 32'h0); else n_pass++;
        n_total++; if (HTRANS_I !== 2'b00) $display("FAIL reset_htrans got=%b exp=00", HTRANS_I); else n_pass++;
        n_total++; if (IF_ID_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", IF_ID_pc); else n_pass++;
        n_total++; if (IF_ID_inst !== BUB) $display("FAIL reset_inst got=%h exp=%h", IF_ID_inst, BUB); else n_pass++;
        n_total++; if (IF_ID_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", IF_ID_valid); else n_pass++;
        n_total++; if (IF_ID_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", IF_ID_err); else n_pass++;
        n_total++; if ({HWRITE_I, HSIZE_I, HBURST_I, HPROT_I, HMASTLOCK_I} !== 12'b0_010_000_0011_0)
            $display("FAIL ahb_consts got=%b exp=%b", {HWRITE_I, HSIZE_I, HBURST_I, HPROT_I, HMASTLOCK_I}, 12'b0_010_000_0011_0);
        else n_pass++;
        n_total++; if (HWDATA_I !== 32'h0) $display("FAIL hwdata got=%h exp=0", HWDATA_I); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        RES = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_total++; if (HADDR_I !== 32'(4 * (k - 1))) $display("FAIL stream_haddr k=%0d got=%h exp=%h", k, HADDR_I, 32'(4 * (k - 1))); else n_pass++;
            n_total++; if (HTRANS_I !== 2'b10) $display("FAIL stream_htrans k=%0d got=%b exp=10", k, HTRANS_I); else n_pass++;
            if (k >= 4) begin
                ep = 32'(4 * (k - 4));
                n_total++; if (IF_ID_valid !== 1'b1 || IF_ID_pc !== ep || IF_ID_inst !== mem(ep))
                    $display("FAIL stream_ifid k=%0d got=%b/%h/%h exp=1/%h/%h", k, IF_ID_valid, IF_ID_pc, IF_ID_inst, ep, mem(ep));
                else n_pass++;
            end else begin
                n_total++; if (IF_ID_valid !== 1'b0 || IF_ID_inst !== BUB) $display("FAIL stream_lat k=%0d got=%b/%h exp=0/%h", k, IF_ID_valid, IF_ID_inst, BUB); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int unsigned nseq = 0;
        int unsigned got = 0;
        logic [31:0] ep = 32'd28;
        stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (HTRANS_I == 2'b10) nseq++;
            n_total++; if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'd24 || IF_ID_inst !== mem(32'd24))
                $display("FAIL stall_frozen k=%0d got=%b/%h/%h exp=1/%h/%h", k, IF_ID_valid, IF_ID_pc, IF_ID_inst, 32'd24, mem(32'd24));
            else n_pass++;
        end
        n_total++; if (nseq != 1) $display("FAIL stall_issue got=%0d exp=1", nseq); else n_pass++;
        stall = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (IF_ID_valid) begin
                n_total++; if (IF_ID_pc !== ep || IF_ID_inst !== mem(ep)) $display("FAIL stall_release got=%h/%h exp=%h/%h", IF_ID_pc, IF_ID_inst, ep, mem(ep)); else n_pass++;
                ep += 4; got++;
            end
        end
        n_total++; if (got < 6) $display("FAIL stall_progress got=%0d exp>=6", got); else n_pass++;
    endtask

    task automatic test_redirect();
        logic        seen = 1'b0;
        logic [31:0] ep = 32'h100;
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        n_total++; if (IF_ID_valid !== 1'b0 || IF_ID_err !== 1'b0 || IF_ID_inst !== BUB) $display("FAIL redir_bubble got=%b/%b/%h exp=0/0/%h", IF_ID_valid, IF_ID_err, IF_ID_inst, BUB); else n_pass++;
        n_total++; if (HTRANS_I !== 2'b00) $display("FAIL redir_idle got=%b exp=00", HTRANS_I); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (IF_ID_valid) begin
                n_total++; if (IF_ID_pc !== ep || IF_ID_inst !== mem(ep)) $display("FAIL redir_target got=%h/%h exp=%h/%h", IF_ID_pc, IF_ID_inst, ep, mem(ep)); else n_pass++;
                ep += 4; seen = 1'b1;
            end
        end
        n_total++; if (!seen) $display("FAIL redir_timeout got=none exp=%h", 32'h100); else n_pass++;
    endtask

    task automatic test_wait();
        logic [31:0] first = NONE;
        k_wait_addr = 32'h4; k_wait_n = 3;
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        tick(); tick(); tick();
        n_total++; if (HADDR_I !== 32'h8 || HTRANS_I !== 2'b10) $display("FAIL wait_a3 got=%h/%b exp=8/10", HADDR_I, HTRANS_I); else n_pass++;
        tick();
        n_total++; if (HADDR_I !== 32'h8 || HTRANS_I !== 2'b10) $display("FAIL wait_a4 got=%h/%b exp=8/10", HADDR_I, HTRANS_I); else n_pass++;
        n_total++; if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h0) $display("FAIL wait_pop0 got=%b/%h exp=1/0", IF_ID_valid, IF_ID_pc); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_total++; if (HADDR_I !== 32'h8 || HTRANS_I !== 2'b10 || IF_ID_valid !== 1'b0) $display("FAIL wait_a5 got=%h/%b/%b exp=8/10/0", HADDR_I, HTRANS_I, IF_ID_valid); else n_pass++;
        tick();
        n_total++; if (HADDR_I !== 32'h8 || HTRANS_I !== 2'b10) $display("FAIL wait_a6 got=%h/%b exp=8/10", HADDR_I, HTRANS_I); else n_pass++;
        tick();
        n_total++; if (HTRANS_I !== 2'b00) $display("FAIL wait_apply got=%b exp=00", HTRANS_I); else n_pass++;
        k_wait_addr = NONE;
        for (int k = 0; k < 10 && first == NONE; k++) begin
            tick();
            if (IF_ID_valid) first = IF_ID_pc;
        end
        n_total++; if (first !== 32'h200) $display("FAIL wait_redir got=%h exp=%h", first, 32'h200); else n_pass++;
    endtask

    task automatic test_error();
        logic        seen = 1'b0;
        logic [31:0] ep = 32'h0;
        logic [31:0] first = NONE;
        k_err_addr = 32'hC;
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 15 && !seen; k++) begin
            tick();
            if (IF_ID_valid || IF_ID_err) begin
                n_total++; if (IF_ID_pc !== ep) $display("FAIL err_seq got=%h exp=%h", IF_ID_pc, ep); else n_pass++;
                if (IF_ID_err) begin
                    seen = 1'b1;
                    n_total++; if (IF_ID_valid !== 1'b0 || IF_ID_inst !== BUB || IF_ID_pc !== 32'hC)
                        $display("FAIL err_entry got=%b/%h/%h exp=0/%h/%h", IF_ID_valid, IF_ID_inst, IF_ID_pc, BUB, 32'hC);
                    else n_pass++;
                end
                ep += 4;
            end
        end
        n_total++; if (!seen) $display("FAIL err_timeout got=none exp=%h", 32'hC); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_total++; if (HTRANS_I !== 2'b00 || IF_ID_valid !== 1'b0) $display("FAIL err_halt k=%0d got=%b/%b exp=00/0", k, HTRANS_I, IF_ID_valid); else n_pass++;
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 10 && first == NONE; k++) begin
            tick();
            if (IF_ID_valid) first = IF_ID_pc;
        end
        n_total++; if (first !== 32'h40) $display("FAIL err_resume got=%h exp=%h", first, 32'h40); else n_pass++;
        k_err_addr = NONE;
    endtask

    task automatic test_reset_mid();
        logic [31:0] ep = 32'h0;
        int unsigned got = 0;
        tick(); tick();
        RES = 1'b0;
        tick();
        RES = 1'b1;
        n_total++; if (HADDR_I !== 32'h0 || HTRANS_I !== 2'b00) $display("FAIL rmid_bus got=%h/%b exp=0/00", HADDR_I, HTRANS_I); else n_pass++;
        n_total++; if (IF_ID_pc !== 32'h0 || IF_ID_inst !== BUB || IF_ID_valid !== 1'b0 || IF_ID_err !== 1'b0)
            $display("FAIL rmid_ifid got=%h/%h/%b/%b exp=0/%h/0/0", IF_ID_pc, IF_ID_inst, IF_ID_valid, IF_ID_err, BUB);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (IF_ID_valid) begin
                n_total++; if (IF_ID_pc !== ep || IF_ID_inst !== mem(ep)) $display("FAIL rmid_restart got=%h/%h exp=%h/%h", IF_ID_pc, IF_ID_inst, ep, mem(ep)); else n_pass++;
                ep += 4; got++;
            end
        end
        n_total++; if (got < 5) $display("FAIL rmid_progress got=%0d exp>=5", got); else n_pass++;
    endtask

    // Model: words reach IF/ID in program order from the last redirect/reset target;
    // the error address ends the stream until the next redirect.
    task automatic test_random();
        logic [31:0] m_next, m_cur_pc, m_cur_inst, exp_inst;
        logic        m_cur_v, m_cur_err, m_halt, m_pc_known, p_red, p_stall, exp_err;
        int unsigned pops = 0;
        k_rand_wait = 1'b1; k_err_addr = 32'hF0;
        RES = 1'b0; redirect = 1'b0; stall = 1'b0;
        tick();
        RES = 1'b1;
        m_next = 32'h0; m_cur_pc = 32'h0; m_cur_inst = BUB; m_cur_v = 1'b0; m_cur_err = 1'b0;
        m_halt = 1'b0; m_pc_known = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            p_stall = ($urandom_range(0, 3) == 0);
            p_red = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            stall = p_stall; redirect = p_red;
            redirect_pc = $urandom_range(0, 511);
            tick();
            if (p_red) begin
                n_total++; if (IF_ID_valid !== 1'b0 || IF_ID_err !== 1'b0 || IF_ID_inst !== BUB) $display("FAIL rnd_redir i=%0d got=%b/%b/%h", i, IF_ID_valid, IF_ID_err, IF_ID_inst); else n_pass++;
                m_next = redirect_pc & 32'hFFFF_FFFC; m_halt = 1'b0; m_pc_known = 1'b0;
                m_cur_v = 1'b0; m_cur_err = 1'b0; m_cur_inst = BUB;
            end else if (p_stall) begin
                n_total++; if (IF_ID_valid !== m_cur_v || IF_ID_err !== m_cur_err || IF_ID_inst !== m_cur_inst || (m_pc_known && IF_ID_pc !== m_cur_pc))
                    $display("FAIL rnd_stall i=%0d got=%b/%b/%h/%h exp=%b/%b/%h/%h", i, IF_ID_valid, IF_ID_err, IF_ID_inst, IF_ID_pc, m_cur_v, m_cur_err, m_cur_inst, m_cur_pc);
                else n_pass++;
            end else if (IF_ID_valid || IF_ID_err) begin
                exp_err = (m_next == k_err_addr);
                exp_inst = exp_err ? BUB : mem(m_next);
                n_total++; if (m_halt || IF_ID_pc !== m_next || IF_ID_err !== exp_err || IF_ID_valid !== !exp_err || IF_ID_inst !== exp_inst)
                    $display("FAIL rnd_pop i=%0d got=%h/%b/%b/%h exp=%h/%b/%b/%h halted=%b", i, IF_ID_pc, IF_ID_err, IF_ID_valid, IF_ID_inst, m_next, exp_err, !exp_err, exp_inst, m_halt);
                else n_pass++;
                m_cur_pc = m_next; m_cur_inst = exp_inst; m_cur_v = !exp_err; m_cur_err = exp_err;
                m_pc_known = 1'b1; m_halt = exp_err; m_next += 4; pops++;
            end else begin
                n_total++; if (IF_ID_inst !== BUB || (m_pc_known && IF_ID_pc !== m_cur_pc))
                    $display("FAIL rnd_bubble i=%0d got=%h/%h exp=%h/%h", i, IF_ID_inst, IF_ID_pc, BUB, m_cur_pc);
                else n_pass++;
                m_cur_v = 1'b0; m_cur_err = 1'b0; m_cur_inst = BUB;
            end
            if (m_halt && !p_red) begin
                n_total++; if (HTRANS_I !== 2'b00) $display("FAIL rnd_halt i=%0d got=%b exp=00", i, HTRANS_I); else n_pass++;
            end
        end
        n_total++; if (pops < 300) $display("FAIL rnd_progress got=%0d exp>=300", pops); else n_pass++;
        stall = 1'b0; redirect = 1'b0; k_rand_wait = 1'b0; k_err_addr = NONE;
    endtask

    initial begin
        HRDATA_I = '0; HREADY_I = 1'b1; HRESP_I = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wait();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
